frame_stream_lsu: RTL and testbench

//  Streaming frame buffer; successor to the free-running load/store unit. Stores pixel beats from the

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_sdp_ram.sv | 21 ++
 rtl/frame_stream_lsu.sv | 89 ++++++++
 tb/tb_frame_stream_lsu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, sizing helpers and pixel parity for the frame stream LSU.
package lsu_pkg;
   localparam int PIXELS_PER_BEAT = 16;
   localparam int BIT_WIDTH = 8;
   localparam int DATA_WIDTH = PIXELS_PER_BEAT * BIT_WIDTH;
   localparam int DEF_IMAGE_DIM = 512;
   function automatic int frame_beats(input int image_dim);
      return image_dim * image_dim / PIXELS_PER_BEAT;
   endfunction
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
   function automatic int fill_width(input int depth);
      return $clog2(depth) + 1;
   endfunction
   localparam int FRAME_BEATS = frame_beats(DEF_IMAGE_DIM);
   localparam int ADDR_WIDTH = addr_width(FRAME_BEATS);
   localparam int FILL_WIDTH = fill_width(FRAME_BEATS);
   typedef logic [ADDR_WIDTH-1:0] lsu_addr_t;
   // One even-parity bit per pixel: set when the pixel has an odd number of ones.
   function automatic logic [PIXELS_PER_BEAT-1:0] pixel_parity(input logic [DATA_WIDTH-1:0] data);
      logic [PIXELS_PER_BEAT-1:0] p;
      for (int i = 0; i < PIXELS_PER_BEAT; i++) p[i] = ^data[i*BIT_WIDTH +: BIT_WIDTH];
      return p;
   endfunction
endpackage

// File: rtl/lsu_sdp_ram.sv
// lsu_sdp_ram: simple dual-port RAM, one write port and one registered read-first read port.
module lsu_sdp_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end
   assign o_rdata = r_rdata;
endmodule

// File: rtl/frame_stream_lsu.sv
// frame_stream_lsu: circular frame buffer replaying producer beats to the consumer with LEAD gating
// and end-of-frame drain. Define LSU_PARITY_EN to store and check per-pixel even parity.
module frame_stream_lsu import lsu_pkg::*; #(
   parameter int IMAGE_DIM   = DEF_IMAGE_DIM,
   parameter int DEPTH_BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
   parameter int LEAD        = 1
) (
   input  logic                               clk,
   input  logic                               aresetn,
   input  logic                               i_wr_valid,
   output logic                               o_wr_ready,
   input  logic [DATA_WIDTH-1:0]              i_wr_data,
   output logic                               o_rd_valid,
   input  logic                               i_rd_ready,
   output logic [DATA_WIDTH-1:0]              o_rd_data,
   output logic                               o_rd_last,
   output logic                               o_frame_done,
   output logic [fill_width(DEPTH_BEATS)-1:0] o_fill_level,
   output logic                               o_par_err
);
   localparam int FB = frame_beats(IMAGE_DIM);
   localparam int AW = addr_width(DEPTH_BEATS);
   localparam int FW = fill_width(DEPTH_BEATS);
   localparam int BW = addr_width(FB);
`ifdef LSU_PARITY_EN
   localparam int RW = DATA_WIDTH + PIXELS_PER_BEAT;
`else
   localparam int RW = DATA_WIDTH;
`endif
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [FW-1:0] r_fill, r_frames;
   logic [BW-1:0] r_wr_beat, r_rd_beat;
   logic          r_rd_valid, r_rd_last;
   logic          w_wr_fire, w_issue, w_avail, w_wr_eof, w_rd_eof;
   logic [RW-1:0] w_wdata, w_q;
   assign o_wr_ready = r_fill < FW'(DEPTH_BEATS);
   assign w_wr_fire  = i_wr_valid && o_wr_ready;
   // A partial frame tail drains once its frame is fully written, otherwise keep LEAD beats in hand.
   assign w_avail    = (r_fill > FW'(LEAD)) || (r_frames != '0 && r_fill != '0);
   assign w_issue    = w_avail && (!r_rd_valid || i_rd_ready);
   assign w_wr_eof   = w_wr_fire && (r_wr_beat == BW'(FB - 1));
   assign w_rd_eof   = w_issue && (r_rd_beat == BW'(FB - 1));
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_frames   <= '0;
         r_wr_beat  <= '0;
         r_rd_beat  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
      end else begin
         if (w_wr_fire) begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_wr_beat <= w_wr_eof ? '0 : r_wr_beat + 1'b1;
         end
         if (w_issue) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rd_beat <= w_rd_eof ? '0 : r_rd_beat + 1'b1;
            r_rd_last <= w_rd_eof;
         end
         r_fill     <= r_fill + FW'(w_wr_fire) - FW'(w_issue);
         r_frames   <= r_frames + FW'(w_wr_eof) - FW'(w_rd_eof);
         r_rd_valid <= w_issue || (r_rd_valid && !i_rd_ready);
      end
   end
`ifdef LSU_PARITY_EN
   assign w_wdata   = {pixel_parity(i_wr_data), i_wr_data};
   assign o_par_err = r_rd_valid && (pixel_parity(w_q[DATA_WIDTH-1:0]) != w_q[RW-1:DATA_WIDTH]);
`else
   assign w_wdata   = i_wr_data;
   assign o_par_err = 1'b0;
`endif
   lsu_sdp_ram #(.WIDTH(RW), .DEPTH(DEPTH_BEATS)) u_ram (
      .clk     (clk),
      .i_we    (w_wr_fire),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_re    (w_issue),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_q)
   );
   assign o_rd_data    = w_q[DATA_WIDTH-1:0];
   assign o_rd_valid   = r_rd_valid;
   assign o_rd_last    = r_rd_last;
   assign o_frame_done = r_rd_valid && i_rd_ready && r_rd_last;
   assign o_fill_level = r_fill;
endmodule

// File: tb/tb_frame_stream_lsu.sv
// tb_frame_stream_lsu: scoreboard bench for a 4-beat-frame, 4-deep buffer with directed and random traffic.
module tb_frame_stream_lsu;
   localparam int DW = 128;
   localparam int FB = 4;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic aresetn = 1'b0;
   logic i_wr_valid = 1'b0;
   logic i_rd_ready = 1'b0;
   logic [DW-1:0] i_wr_data = '0;
   logic o_wr_ready, o_rd_valid, o_rd_last, o_frame_done, o_par_err;
   logic [DW-1:0] o_rd_data;
   logic [2:0] o_fill_level;
   typedef struct packed { logic [DW-1:0] data; logic last; } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   int acc = 0, pops = 0, fd_cnt = 0;
   logic hold = 1'b0;
   logic [DW-1:0] held;
   logic wdone;
   frame_stream_lsu #(.IMAGE_DIM(8), .LEAD(1)) dut (
      .clk(clk), .aresetn(aresetn), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
      .i_wr_data(i_wr_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
      .o_rd_last(o_rd_last), .o_frame_done(o_frame_done), .o_fill_level(o_fill_level), .o_par_err(o_par_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Model: beats leave in acceptance order; every FB-th accepted beat since reset ends a frame;
   // beats accepted = beats in RAM (fill) + beat held at the output + beats consumed.
   always @(negedge clk) begin
      if (!aresetn) begin
         q.delete();
         acc = 0;
         pops = 0;
         hold = 1'b0;
      end else begin
         exp_t e;
         chk("fill_conservation", DW'(o_fill_level), DW'(acc - pops - int'(o_rd_valid)));
         chk("par_err", DW'(o_par_err), '0);
         if (hold) begin
            chk("stall_valid", DW'(o_rd_valid), DW'(1));
            chk("stall_data", o_rd_data, held);
         end
         hold = o_rd_valid && !i_rd_ready;
         held = o_rd_data;
         if (o_rd_valid && i_rd_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %0h expected none", o_rd_data);
            end else begin
               e = q.pop_front();
               chk("rd_data", o_rd_data, e.data);
               chk("rd_last", DW'(o_rd_last), DW'(e.last));
               chk("frame_done", DW'(o_frame_done), DW'(e.last));
            end
            pops++;
         end else chk("frame_done_idle", DW'(o_frame_done), '0);
         if (o_frame_done) fd_cnt++;
         if (i_wr_valid && o_wr_ready) begin
            e.data = i_wr_data;
            e.last = (acc % FB) == FB - 1;
            q.push_back(e);
            acc++;
         end
      end
   end
   function automatic logic [DW-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic do_reset();
      i_wr_valid = 1'b0;
      aresetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_valid", DW'(o_rd_valid), '0);
      chk("rst_fill", DW'(o_fill_level), '0);
      chk("rst_wr_ready", DW'(o_wr_ready), DW'(1));
      chk("rst_rd_last", DW'(o_rd_last), '0);
      chk("rst_frame_done", DW'(o_frame_done), '0);
      @(posedge clk);
      #1 aresetn = 1'b1;
   endtask
   task automatic write_beat(input logic [DW-1:0] d);
      i_wr_valid = 1'b1;
      i_wr_data = d;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (o_wr_ready) begin
            @(posedge clk);
            #1 i_wr_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      errors++;
      $display("FAIL write_timeout: got no wr_ready expected wr_ready within 200 cycles");
      i_wr_valid = 1'b0;
   endtask
   task automatic wait_q(input int left, input string name);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (q.size() <= left) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL %s: got %0d queued expected %0d", name, q.size(), left);
   endtask
   initial begin
      int n;
      int cyc;
      // reset and idle
      do_reset();
      repeat (5) begin
         @(negedge clk);
         chk("idle_no_valid", DW'(o_rd_valid), '0);
      end
      // LEAD gating
      @(posedge clk);
      #1 i_rd_ready = 1'b1;
      write_beat(DW'(8'hA0));
      @(negedge clk);
      chk("lead_one_beat_valid", DW'(o_rd_valid), '0);
      chk("lead_one_beat_fill", DW'(o_fill_level), DW'(1));
      @(posedge clk);
      #1 write_beat(DW'(8'hA1));
      @(negedge clk);
      chk("lead_issue_pending", DW'(o_rd_valid), '0);
      @(negedge clk);
      chk("lead_first_out", DW'(o_rd_valid), DW'(1));
      chk("lead_first_data", o_rd_data, DW'(8'hA0));
      @(negedge clk);
      chk("lead_hold_back", DW'(o_rd_valid), '0);
      chk("lead_fill", DW'(o_fill_level), DW'(1));
      // frame drain
      do_reset();
      fd_cnt = 0;
      for (int i = 0; i < FB; i++) write_beat(DW'(8'hB0 + i));
      wait_q(0, "drain_timeout");
      repeat (3) @(negedge clk);
      chk("drain_fill", DW'(o_fill_level), '0);
      chk("drain_valid", DW'(o_rd_valid), '0);
      chk("drain_frame_done_count", DW'(fd_cnt), DW'(1));
      // full / backpressure: one beat sits in the output register besides DEPTH in RAM
      do_reset();
      i_rd_ready = 1'b0;
      n = 0;
      i_wr_valid = 1'b1;
      for (int c = 0; c < DEPTH + 3; c++) begin
         i_wr_data = DW'(16'hC000 + n);
         @(negedge clk);
         if (o_wr_ready) n++;
         @(posedge clk);
         #1;
      end
      i_wr_valid = 1'b0;
      @(negedge clk);
      chk("full_accepts", DW'(n), DW'(DEPTH + 1));
      chk("full_fill", DW'(o_fill_level), DW'(DEPTH));
      chk("full_wr_ready", DW'(o_wr_ready), '0);
      @(posedge clk);
      #1 i_rd_ready = 1'b1;
      wait_q(1, "full_drain_timeout");
      repeat (2) @(negedge clk);
      chk("full_wr_ready_back", DW'(o_wr_ready), DW'(1));
      chk("full_tail_fill", DW'(o_fill_level), DW'(1));
      // random traffic over three frames with pointer wrap
      do_reset();
      wdone = 1'b0;
      cyc = 0;
      fork
         begin
            for (int i = 0; i < 3 * FB; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #0 write_beat(rnd());
            end
            wdone = 1'b1;
         end
         begin
            while (!(wdone && q.size() == 0) && cyc < 2000) begin
               @(posedge clk);
               #1 i_rd_ready = 1'($urandom_range(0, 1));
               cyc++;
            end
         end
      join
      chk("random_complete", DW'(cyc < 2000), DW'(1));
      i_rd_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("random_fill_zero", DW'(o_fill_level), '0);
      // mid-frame reset
      @(posedge clk);
      #1 write_beat(DW'(8'hD0));
      write_beat(DW'(8'hD1));
      do_reset();
      chk("mid_reset_queue_cleared", DW'(q.size()), '0);
      fd_cnt = 0;
      for (int i = 0; i < FB; i++) write_beat(DW'(8'hE0 + i));
      wait_q(0, "mid_reset_drain_timeout");
      repeat (3) @(negedge clk);
      chk("mid_reset_frame_done_count", DW'(fd_cnt), DW'(1));
      chk("mid_reset_fill", DW'(o_fill_level), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
